hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage pipeline. Each cycle it drives the write_enable/flush pair of the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) plus the PC write enable. It resolves memory-wait stalls, multi-cycle divide stalls, taken-branch flushes, load-use bubbles and post-reset pipeline clearing. It keeps a stall counter and a memory-wait watchdog.

## Interface
- CNT_W, 32: width of the stall counter.
- MAX_WAIT, 255: MEM_WAIT cycles before the watchdog fires (1..2^16-1).
- clk  in  1  clock; state updates on posedge.
- Rst  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- ex_div_start  in  1  divide issued from EX this cycle (1-cycle pulse).
- div_done  in  1  divider result valid (1-cycle pulse).
- mem_req  in  1  load/store in MEM needs data memory.
- mem_ready  in  1  data memory completes this cycle.
- pc_we  out  1  PC write enable.
- ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_we, memwb_flush  out  1  per-register controls.
- stall_cnt  out  CNT_W  cycles with pc_we=0 outside INIT; saturating.
- mem_timeout  out  1  sticky watchdog flag.

## Operation
- States (2-bit): INIT=00, RUN=01, DIV_WAIT=10, MEM_WAIT=11.
- A flush is meaningful only with its we=1. Every flush output is asserted only together with its we.
- "Normal": all we=1, all flush=0, pc_we=1.
- INIT: pc_we=0; all four we=1 and flush=1. Held exactly 2 cycles after reset release, then RUN.
- RUN rules, in priority order:
  - R1, mem_req && !mem_ready: pc/ifid/idex/exmem we=0; memwb we=1, flush=1. Next state MEM_WAIT.
  - R2, ex_div_start: pc/ifid/idex we=0; exmem we=1, flush=1; memwb we=1, flush=0. Next state DIV_WAIT.
  - R3, ex_branch_taken: normal, plus ifid_flush=1 and idex_flush=1. Stay in RUN.
  - R4, load-use. Condition: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)). Response: pc_we=0, ifid_we=0; idex we=1, flush=1; exmem/memwb normal. Stay in RUN.
  - R5, otherwise: normal.
- DIV_WAIT:
  - While !div_done: outputs as R2.
  - On div_done: normal for that cycle, next RUN.
  - mem_req, ex_div_start and ex_branch_taken are ignored in this state.
- MEM_WAIT:
  - While !mem_ready: outputs as R1; wait_cnt increments.
  - On mem_ready (release cycle): outputs and next state follow RUN rules R2–R5, so a branch or divide frozen in EX is honoured. Without R2, next state is RUN.
- Watchdog:
  - wait_cnt clears on entry to MEM_WAIT.
  - When wait_cnt reaches MAX_WAIT, mem_timeout is set and stays 1 until reset.
  - The FSM keeps waiting; it never leaves MEM_WAIT on timeout.
- stall_cnt: +1 on each posedge where state!=INIT and pc_we=0. Saturates at all-ones.
- Arithmetic: the ex_rd==0 guard means x0 never creates a hazard. All compares are 5-bit unsigned equality.

## Timing
- State, init counter, wait_cnt, stall_cnt and mem_timeout are registered on posedge clk.
- Control outputs are combinational from state and inputs. They must settle within the first half-cycle, because the pipeline registers capture on negedge clk.
- Reset (Rst=0, async):
  - state=INIT, init_cnt=0, wait_cnt=0, stall_cnt=0, mem_timeout=0.
  - Outputs immediately take INIT values: pc_we=0, all we=1, all flush=1.
- Reset mid-operation aborts any wait. A div_done or mem_ready arriving after reset is ignored unless the current state consumes it.
- Simultaneous events:
  - mem stall beats divide, branch and load-use.
  - div_start beats branch; the branch stays in EX and fires on exit.
  - Branch beats load-use; the flushed ID instruction makes the hazard moot.
- Latency:
  - Load-use costs exactly 1 bubble.
  - Branch costs 2 flushed slots.
  - Divide stalls 1+N cycles, where N is the cycles from DIV_WAIT entry to div_done.
- The stall decision for a cycle is made in that same cycle; there is no extra registered delay.

## Test plan
- Reset release: Rst 0→1 → 2 cycles with pc_we=0 and all flush=1, then normal; stall_cnt=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle with pc_we=0, ifid_we=0, idex_flush=1. With ex_rd=0 the same stimulus gives no stall.
- Branch while load-use: ex_branch_taken=1 with the hazard above → ifid_flush=idex_flush=1, pc_we=1, stall_cnt unchanged.
- Divide: ex_div_start pulse, div_done 4 cycles later → 5 cycles with pc_we=0 and exmem_flush=1, then normal; stall_cnt=5.
- Memory wait with pending branch: mem_req=1, mem_ready=0 for 3 cycles while ex_branch_taken=1 → memwb_flush=1 for 3 cycles. Release cycle gives ifid_flush=idex_flush=1.
- Watchdog: MAX_WAIT=4, mem_ready held 0 → mem_timeout=1 after the 4th wait cycle. It stays 1 after mem_ready and clears only on Rst=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the 5-stage pipeline and its hazard controller.
//
// Pipeline -> controller (hazard sources):
//   id_rs1, id_rs2           source registers of the ID instruction
//   id_uses_rs1, id_uses_rs2 ID instruction really reads rs1 / rs2
//   ex_mem_read, ex_rd       EX instruction is a load, and its destination
//   ex_branch_taken          branch/jump resolved taken in EX
//   ex_div_start             divide issued from EX (1-cycle pulse)
//   div_done                 divider result valid (1-cycle pulse)
//   mem_req, mem_ready       MEM stage memory request / completion
// Controller -> pipeline (register controls and status):
//   pc_we                    PC write enable
//   <reg>_we, <reg>_flush    for ifid, idex, exmem, memwb
//   stall_cnt                saturating count of stalled cycles
//   mem_timeout              sticky memory-wait watchdog flag
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             ex_div_start;
  logic             div_done;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_we;
  logic             idex_flush;
  logic             exmem_we;
  logic             exmem_flush;
  logic             memwb_we;
  logic             memwb_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;

  // Pipeline side: raises hazard sources, consumes register controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, ex_div_start, div_done, mem_req, mem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
           exmem_flush, memwb_we, memwb_flush, stall_cnt, mem_timeout
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, ex_div_start, div_done, mem_req, mem_ready,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
           exmem_flush, memwb_we, memwb_flush, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage pipeline.
//
// Drives write-enable/flush for IF/ID, ID/EX, EX/MEM, MEM/WB and the PC write
// enable. Resolves memory-wait stalls, multi-cycle divide stalls, taken-branch
// flushes, load-use bubbles and the 2-cycle pipeline clear after reset.
//
// Ports:
//   clk   clock, state updates on posedge
//   Rst   asynchronous active-low reset
//   hz    hazard_ctrl_if.slave bundle (hazard sources in, controls/status out)
//
// Parameters:
//   CNT_W     width of the saturating stall counter
//   MAX_WAIT  MEM_WAIT cycles before mem_timeout is raised (1..65535)
//
// Controls are combinational from state and inputs so that the pipeline
// registers, which capture on negedge, see this cycle's decision.
module hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 255
) (
  input logic          clk,
  input logic          Rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    INIT     = 2'b00,
    RUN      = 2'b01,
    DIV_WAIT = 2'b10,
    MEM_WAIT = 2'b11
  } state_t;

  // Control word layout:
  // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
  //  exmem_we, exmem_flush, memwb_we, memwb_flush}
  localparam logic [8:0] CTL_INIT = 9'b0_11_11_11_11;
  localparam logic [8:0] CTL_NORM = 9'b1_10_10_10_10;
  localparam logic [8:0] CTL_BR   = 9'b1_11_11_10_10;
  localparam logic [8:0] CTL_LU   = 9'b0_00_11_10_10;
  localparam logic [8:0] CTL_DIV  = 9'b0_00_00_11_10;
  localparam logic [8:0] CTL_MEM  = 9'b0_00_00_00_11;

  localparam logic [15:0]      MAX_WAIT_C = 16'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             init_cnt;
  logic [15:0]      wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_timeout;

  logic             mem_stall;
  logic             load_use;
  logic [8:0]       run_ctl;
  state_t           run_nxt;
  logic [8:0]       ctl;

  assign mem_stall = hz.mem_req && !hz.mem_ready;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // RUN rules below the memory stall. Shared by RUN (after the mem check) and
  // by the MEM_WAIT release cycle, so a divide or branch frozen in EX during
  // the memory wait is honoured as soon as memory completes. A divide holds
  // the branch in EX; a branch flushes ID, making any load-use moot.
  always_comb begin
    run_ctl = CTL_NORM;
    run_nxt = RUN;
    if (hz.ex_div_start) begin
      run_ctl = CTL_DIV;
      run_nxt = DIV_WAIT;
    end else if (hz.ex_branch_taken) begin
      run_ctl = CTL_BR;
    end else if (load_use) begin
      run_ctl = CTL_LU;
    end
  end

  always_comb begin
    ctl       = CTL_NORM;
    state_nxt = state;
    case (state)
      INIT: begin
        ctl = CTL_INIT;
        if (init_cnt) state_nxt = RUN;
      end
      RUN: begin
        if (mem_stall) begin
          ctl       = CTL_MEM;
          state_nxt = MEM_WAIT;
        end else begin
          ctl       = run_ctl;
          state_nxt = run_nxt;
        end
      end
      MEM_WAIT: begin
        if (!hz.mem_ready) begin
          ctl = CTL_MEM;
        end else begin
          ctl       = run_ctl;
          state_nxt = run_nxt;
        end
      end
      DIV_WAIT: begin
        // Memory, divide-start and branch inputs are ignored while dividing.
        if (!hz.div_done) begin
          ctl = CTL_DIV;
        end else begin
          ctl       = CTL_NORM;
          state_nxt = RUN;
        end
      end
      default: begin
        ctl       = CTL_INIT;
        state_nxt = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state       <= INIT;
      init_cnt    <= 1'b0;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;

      // Second INIT cycle is the one with init_cnt already set.
      if (state == INIT) init_cnt <= 1'b1;

      if ((state != MEM_WAIT) && (state_nxt == MEM_WAIT)) begin
        wait_cnt <= '0;
      end else if ((state == MEM_WAIT) && !hz.mem_ready) begin
        if (wait_cnt != MAX_WAIT_C) wait_cnt <= wait_cnt + 16'd1;
        // Flag raised on the edge where the count reaches MAX_WAIT.
        if ((wait_cnt + 16'd1) == MAX_WAIT_C) mem_timeout <= 1'b1;
      end

      if ((state != INIT) && !ctl[8] && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_we, hz.idex_flush,
          hz.exmem_we, hz.exmem_flush, hz.memwb_we, hz.memwb_flush} = ctl;
  assign hz.stall_cnt   = stall_cnt;
  assign hz.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. Each step drives inputs
// just after posedge, queues the expected control word, stall count and
// timeout flag, then compares at the following negedge.
module tb_hazard_ctrl;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
  //  exmem_we, exmem_flush, memwb_we, memwb_flush}
  localparam logic [8:0] INITV = 9'b011111111;
  localparam logic [8:0] NORM  = 9'b110101010;
  localparam logic [8:0] BR    = 9'b111111010;
  localparam logic [8:0] LU    = 9'b000111010;
  localparam logic [8:0] DIV   = 9'b000001110;
  localparam logic [8:0] MEM   = 9'b000000011;

  typedef struct {
    string            tag;
    logic [8:0]       ctl;
    logic [CNT_W-1:0] sc;
    logic             tmo;
  } exp_t;

  logic clk = 1'b0;
  logic Rst;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .Rst (Rst),
    .hz  (bus)
  );

  always #5 clk = ~clk;

  exp_t             sb[$];
  int               n_assert = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_stall;
  logic [8:0]       obs_ctl;

  assign obs_ctl = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we,
                    bus.idex_flush, bus.exmem_we, bus.exmem_flush,
                    bus.memwb_we, bus.memwb_flush};

  task automatic clear_in();
    bus.id_rs1          = 5'd0;
    bus.id_rs2          = 5'd0;
    bus.id_uses_rs1     = 1'b0;
    bus.id_uses_rs2     = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_rd           = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_div_start    = 1'b0;
    bus.div_done        = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_ready       = 1'b0;
  endtask

  task automatic push(input string tag, input logic [8:0] ctl, input logic tmo);
    exp_t e;
    e.tag = tag;
    e.ctl = ctl;
    e.sc  = exp_stall;
    e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 entries required=1");
      return;
    end
    e = sb.pop_front();
    n_assert++;
    assert (obs_ctl === e.ctl) else begin
      n_fail++;
      $error("FAIL %s ctl observed=%b required=%b", e.tag, obs_ctl, e.ctl);
    end
    n_assert++;
    assert (bus.stall_cnt === e.sc) else begin
      n_fail++;
      $error("FAIL %s stall_cnt observed=%0d required=%0d", e.tag, bus.stall_cnt, e.sc);
    end
    n_assert++;
    assert (bus.mem_timeout === e.tmo) else begin
      n_fail++;
      $error("FAIL %s mem_timeout observed=%b required=%b", e.tag, bus.mem_timeout, e.tmo);
    end
  endtask

  // One clock cycle: inputs already driven; check at negedge, then advance
  // the stall model and move to just after the next posedge.
  task automatic step(input string tag, input logic [8:0] ctl,
                      input logic init_cyc, input logic tmo);
    push(tag, ctl, tmo);
    @(negedge clk);
    compare_head();
    if (!init_cyc && !ctl[8] && (exp_stall != '1)) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must take INIT values without a clock edge.
  task automatic reset_now(input string tag);
    Rst       = 1'b0;
    exp_stall = '0;
    #1;
    push(tag, INITV, 1'b0);
    compare_head();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    Rst       = 1'b0;
    exp_stall = '0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    step("reset_hold", INITV, 1'b1, 1'b0);

    // Release: exactly two clearing cycles, then normal flow.
    Rst = 1'b1;
    step("init_c0", INITV, 1'b1, 1'b0);
    step("init_c1", INITV, 1'b1, 1'b0);
    step("run_idle", NORM, 1'b0, 1'b0);

    // Load-use on rs2: one bubble.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
    step("lu_rs2", LU, 1'b0, 1'b0);
    clear_in();
    step("lu_after", NORM, 1'b0, 1'b0);
    // Load into x0 never stalls.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0; bus.id_uses_rs2 = 1'b1;
    step("lu_x0", NORM, 1'b0, 1'b0);
    // Load-use on rs1.
    clear_in();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_uses_rs1 = 1'b1;
    bus.id_rs2 = 5'd3; bus.id_uses_rs2 = 1'b1;
    step("lu_rs1", LU, 1'b0, 1'b0);
    bus.id_uses_rs1 = 1'b0;
    step("lu_unused", NORM, 1'b0, 1'b0);
    bus.id_uses_rs1 = 1'b1; bus.ex_mem_read = 1'b0;
    step("lu_noload", NORM, 1'b0, 1'b0);

    // Branch beats load-use.
    clear_in();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
    bus.ex_branch_taken = 1'b1;
    step("br_over_lu", BR, 1'b0, 1'b0);
    clear_in();
    step("br_after", NORM, 1'b0, 1'b0);

    // Divide beats branch; 1 + 4 stalled cycles, other inputs ignored.
    bus.ex_div_start = 1'b1; bus.ex_branch_taken = 1'b1;
    step("div_start", DIV, 1'b0, 1'b0);
    bus.ex_div_start = 1'b0; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("div_wait", DIV, 1'b0, 1'b0);
    bus.mem_req = 1'b0; bus.div_done = 1'b1;
    step("div_done", NORM, 1'b0, 1'b0);
    clear_in();
    step("div_after", NORM, 1'b0, 1'b0);

    // Memory wait with a branch pending in EX.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) step("mem_br_wait", MEM, 1'b0, 1'b0);
    bus.mem_ready = 1'b1;
    step("mem_br_release", BR, 1'b0, 1'b0);
    clear_in();
    step("mem_br_after", NORM, 1'b0, 1'b0);

    // Memory stall beats divide and load-use; divide honoured on release.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.ex_div_start = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
    step("mem_over_div", MEM, 1'b0, 1'b0);
    bus.mem_ready = 1'b1;
    step("mem_rel_div", DIV, 1'b0, 1'b0);
    clear_in();
    step("rel_div_wait", DIV, 1'b0, 1'b0);
    bus.div_done = 1'b1;
    step("rel_div_done", NORM, 1'b0, 1'b0);
    clear_in();
    step("rel_div_after", NORM, 1'b0, 1'b0);

    // Watchdog: flag after the 4th MEM_WAIT cycle, FSM keeps waiting,
    // stall counter saturates at 15 along the way.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    step("wd_entry", MEM, 1'b0, 1'b0);
    for (int i = 0; i < MAX_WAIT; i++) step("wd_wait", MEM, 1'b0, 1'b0);
    step("wd_fired", MEM, 1'b0, 1'b1);
    step("wd_still_wait", MEM, 1'b0, 1'b1);
    bus.mem_ready = 1'b1;
    step("wd_release", NORM, 1'b0, 1'b1);
    clear_in();
    step("wd_sticky", NORM, 1'b0, 1'b1);

    // Reset in the middle of a memory wait; late completions ignored.
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    step("pre_rst_wait", MEM, 1'b0, 1'b1);
    reset_now("rst_async");
    bus.mem_req = 1'b0; bus.mem_ready = 1'b1; bus.div_done = 1'b1;
    @(posedge clk);
    #1;
    Rst = 1'b1;
    step("rst_init_c0", INITV, 1'b1, 1'b0);
    step("rst_init_c1", INITV, 1'b1, 1'b0);
    step("post_rst", NORM, 1'b0, 1'b0);
    clear_in();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; bus.id_uses_rs1 = 1'b1;
    step("post_rst_lu", LU, 1'b0, 1'b0);
    clear_in();
    step("post_rst_cnt", NORM, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
